// File: rtl/addr_stream_arb.sv
// rtl/addr_stream_arb.sv - shared read/write address generator arbitrating NUM_CH accelerator channels
//
// One read counter and one write counter produce a registered RAM address
// stream for the channel latched on start. Read and write beats alternate
// round-robin when both are eligible, and a write is never issued for a word
// that has not been read yet.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   start, abort        1-cycle control pulses
//   ch_sel, offset,     transfer configuration, sampled on an accepted start
//   filesize
//   rd_pause, wr_pause  per-channel stalls for the read / write direction
//   addr, addr_vld,     registered RAM beat: address, valid, 1 = write
//   addr_wr
//   rd_done, wr_done    per-channel completion levels
//   busy                transfer in progress
//   cfg_err             1-cycle pulse when a start is rejected
module addr_stream_arb #(
  parameter int                ADDR_W     = 32,
  parameter int                NUM_CH     = 3,
  parameter int                CH_W       = 2,
  parameter logic [NUM_CH-1:0] EXTRA_MASK = 3'b110
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [CH_W-1:0]   ch_sel,
  input  logic [ADDR_W-1:0] offset,
  input  logic [ADDR_W-1:0] filesize,
  input  logic [NUM_CH-1:0] rd_pause,
  input  logic [NUM_CH-1:0] wr_pause,
  output logic [ADDR_W-1:0] addr,
  output logic              addr_vld,
  output logic              addr_wr,
  output logic [NUM_CH-1:0] rd_done,
  output logic [NUM_CH-1:0] wr_done,
  output logic              busy,
  output logic              cfg_err
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   base_q;
  // One bit wider than the address so filesize = all-ones plus the tail word fits.
  logic [ADDR_W:0]     len_q;
  logic [ADDR_W:0]     rd_cnt_q;
  logic [ADDR_W:0]     wr_cnt_q;
  // Latched channel kept one-hot so stall and done selection are simple masks.
  logic [NUM_CH-1:0]   ch_oh_q;
  logic                last_wr_q;

  logic [NUM_CH-1:0]   new_oh;
  logic                new_extra;
  logic                cfg_ok;
  logic                rd_p, wr_p;
  logic                rd_fin, wr_fin;
  logic                rd_ok, wr_ok;
  logic                grant_vld, grant_wr;

  always_comb begin
    new_oh    = '0;
    new_extra = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_sel == CH_W'(i)) begin
        new_oh[i] = 1'b1;
        new_extra = EXTRA_MASK[i];
      end
    end
    // An out-of-range ch_sel matches no channel, leaving new_oh empty.
    cfg_ok    = (|new_oh) && (filesize != '0);

    rd_p      = |(rd_pause & ch_oh_q);
    wr_p      = |(wr_pause & ch_oh_q);
    rd_fin    = (rd_cnt_q == len_q);
    wr_fin    = (wr_cnt_q == len_q);
    rd_ok     = (rd_cnt_q < len_q) && !rd_p;
    wr_ok     = (wr_cnt_q < len_q) && (wr_cnt_q < rd_cnt_q) && !wr_p;
    grant_vld = rd_ok || wr_ok;
    // Write wins if it is the only candidate, or if both compete and the previous grant was a read.
    grant_wr  = wr_ok && (!rd_ok || !last_wr_q);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start && cfg_ok) state_d = S_RUN;
      S_RUN: begin
        if (abort)                 state_d = S_IDLE;
        else if (rd_fin && wr_fin) state_d = S_FIN;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      base_q    <= '0;
      len_q     <= '0;
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
      ch_oh_q   <= '0;
      last_wr_q <= 1'b1;
      addr      <= '0;
      addr_vld  <= 1'b0;
      addr_wr   <= 1'b0;
      rd_done   <= '0;
      wr_done   <= '0;
      busy      <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cfg_err  <= 1'b0;
      addr_vld <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (!cfg_ok) begin
              cfg_err <= 1'b1;
            end else begin
              base_q   <= offset;
              len_q    <= {1'b0, filesize} + {{ADDR_W{1'b0}}, new_extra};
              rd_cnt_q <= '0;
              wr_cnt_q <= '0;
              ch_oh_q  <= new_oh;
              rd_done  <= '0;
              wr_done  <= '0;
              busy     <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (abort) begin
            busy <= 1'b0;
          end else begin
            if (rd_fin) rd_done <= rd_done | ch_oh_q;
            if (wr_fin) wr_done <= wr_done | ch_oh_q;
            if (grant_vld) begin
              addr      <= base_q + (grant_wr ? wr_cnt_q[ADDR_W-1:0] : rd_cnt_q[ADDR_W-1:0]);
              addr_vld  <= 1'b1;
              addr_wr   <= grant_wr;
              last_wr_q <= grant_wr;
              if (grant_wr) wr_cnt_q <= wr_cnt_q + (ADDR_W+1)'(1);
              else          rd_cnt_q <= rd_cnt_q + (ADDR_W+1)'(1);
            end
          end
        end
        S_FIN:   busy <= 1'b0;
        default: busy <= 1'b0;
      endcase
    end
  end

endmodule
